iter_divider: RTL and testbench

Iterative radix-2 restoring divider that responds to the CPU's multiply/divide bridge over a pair of AXI-stream-style operand channels and one result channel. Instantiated twice beside the HI/LO register logic: once with `SIGNED=1` for DIV and once with `SIGNED=0` for DIVU. Accepts one operand pair at a time and returns `{quotient, remainder}` as a single-cycle valid pulse a fixed 33 cycles later.

---
 rtl/iter_divider.sv | 165 ++++++++++++++++
 tb/tb_iter_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Radix-2 restoring divider, 32/32 -> {quotient, remainder}, 33-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
  parameter int SIGNED = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_dividend_tvalid,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata,
  output logic        busy
);

  localparam logic       c_signed    = (SIGNED != 0);
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_calc   = 2'd1;
  localparam logic [1:0] c_st_fix    = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;
  localparam logic [4:0] c_last_iter = 5'd31;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_calc;
  logic        w_fix;
  logic        w_done;

  logic [31:0] r_q;
  logic [31:0] r_d;
  logic [31:0] r_r;
  logic [4:0]  r_cnt;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_dz;
  logic        r_dout_tvalid;
  logic [63:0] r_dout_tdata;
  logic        r_busy;

  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_trial;
  logic [31:0] w_quot_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
          w_state_nxt = c_st_calc;
        end
      end
      c_st_calc: begin
        if (r_cnt == c_last_iter) begin
          w_state_nxt = c_st_fix;
        end
      end
      c_st_fix:  w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_accept = 1'b0;
    w_calc   = 1'b0;
    w_fix    = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      c_st_idle: w_accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
      c_st_calc: w_calc   = 1'b1;
      c_st_fix:  w_fix    = 1'b1;
      c_st_done: w_done   = 1'b1;
      default:   w_done   = 1'b0;
    endcase
  end

  assign w_dvd_neg = c_signed & s_axis_dividend_tdata[31];
  assign w_dvs_neg = c_signed & s_axis_divisor_tdata[31];
  assign w_dvd_mag = w_dvd_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
  assign w_dvs_mag = w_dvs_neg ? (32'd0 - s_axis_divisor_tdata)  : s_axis_divisor_tdata;

  assign w_trial = {r_r, r_q[31]} - {1'b0, r_d};

  // The algorithm already yields all-ones for a zero divisor; the mux just makes it explicit.
  assign w_quot_mag = r_dz ? 32'hFFFF_FFFF : r_q;
  assign w_quot     = r_qneg ? (32'd0 - w_quot_mag) : w_quot_mag;
  assign w_rem      = r_rneg ? (32'd0 - r_r) : r_r;

  // Iteration datapath
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q    <= 32'd0;
      r_d    <= 32'd0;
      r_r    <= 32'd0;
      r_cnt  <= 5'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_q    <= w_dvd_mag;
      r_d    <= w_dvs_mag;
      r_r    <= 32'd0;
      r_cnt  <= 5'd0;
      r_qneg <= w_dvd_neg ^ w_dvs_neg;
      r_rneg <= w_dvd_neg;
      r_dz   <= (s_axis_divisor_tdata == 32'd0);
    end else if (w_calc) begin
      if (!w_trial[32]) begin
        r_r <= w_trial[31:0];
        r_q <= {r_q[30:0], 1'b1};
      end else begin
        r_r <= {r_r[30:0], r_q[31]};
        r_q <= {r_q[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Result and busy registers; tdata holds until the next FIX
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_dout_tvalid <= 1'b0;
      r_dout_tdata  <= 64'd0;
      r_busy        <= 1'b0;
    end else begin
      r_dout_tvalid <= w_fix;
      if (w_fix) begin
        r_dout_tdata <= {w_quot, w_rem};
      end
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign m_axis_dout_tvalid = r_dout_tvalid;
  assign m_axis_dout_tdata  = r_dout_tdata;
  assign busy               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Directed bench for iter_divider, signed and unsigned instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        dvd_valid = 1'b0;
  logic        dvs_valid = 1'b0;
  logic [31:0] dvd = 32'd0;
  logic [31:0] dvs = 32'd0;

  logic        s_tvalid, u_tvalid, s_busy, u_busy;
  logic [63:0] s_tdata, u_tdata;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  iter_divider #(.SIGNED(1)) u_div_s (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs),
    .m_axis_dout_tvalid     (s_tvalid),
    .m_axis_dout_tdata      (s_tdata),
    .busy                   (s_busy)
  );

  iter_divider #(.SIGNED(0)) u_div_u (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs),
    .m_axis_dout_tvalid     (u_tvalid),
    .m_axis_dout_tdata      (u_tdata),
    .busy                   (u_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a pair, waits (bounded) for acceptance, then checks the 33-cycle result.
  // interfere: a second pair is offered at E5. chain: next pair offered while tvalid is high.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_s, input logic [63:0] exp_u,
                       input bit interfere, input bit chain,
                       input logic [31:0] nxt_a, input logic [31:0] nxt_b);
    int   waited;
    logic early;
    logic busy_drop;
    dvd = a; dvs = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    waited = 0;
    while (!(s_busy && u_busy) && waited < 3) begin
      @(posedge aclk); #1;
      waited++;
    end
    check({tag, " accept"}, {62'd0, s_busy, u_busy}, 64'd3);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    early = 1'b0;
    busy_drop = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge aclk); #1;
      if (k < 33) begin
        early     = early | s_tvalid | u_tvalid;
        busy_drop = busy_drop | !(s_busy && u_busy);
      end
      if (interfere && k == 4) begin
        dvd = 32'd50; dvs = 32'd5; dvd_valid = 1'b1; dvs_valid = 1'b1;
      end
      if (interfere && k == 5) begin
        dvd_valid = 1'b0; dvs_valid = 1'b0;
      end
    end
    check({tag, " quiet/busy before E33"}, {62'd0, early, busy_drop}, 64'd0);
    check({tag, " tvalid E33"}, {62'd0, s_tvalid, u_tvalid}, 64'd3);
    check({tag, " signed tdata"}, s_tdata, exp_s);
    check({tag, " unsigned tdata"}, u_tdata, exp_u);
    check({tag, " busy E33"}, {62'd0, s_busy, u_busy}, 64'd3);
    if (chain) begin
      dvd = nxt_a; dvs = nxt_b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    end
    @(posedge aclk); #1;
    check({tag, " tvalid E34"}, {62'd0, s_tvalid, u_tvalid}, 64'd0);
    check({tag, " hold tdata E34"}, {s_tdata[31:0], u_tdata[31:0]}, {exp_s[31:0], exp_u[31:0]});
    if (!chain) begin
      check({tag, " busy E34"}, {62'd0, s_busy, u_busy}, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    repeat (3) @(posedge aclk);
    #1;
    check("reset tvalid/busy", {60'd0, s_tvalid, u_tvalid, s_busy, u_busy}, 64'd0);
    check("reset tdata s", s_tdata, 64'd0);
    check("reset tdata u", u_tdata, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    do_op("100/7", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("-7/2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("7/-2", 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 64'h00000000_00000007, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("ovf", 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 64'h00000000_80000000, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("max/1", 32'hFFFFFFFF, 32'd1, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("dz pos", 32'h12345678, 32'd0, 64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678, 1'b0, 1'b0, 32'd0, 32'd0);
    do_op("dz neg", 32'hFFFFFF00, 32'd0, 64'h00000001_FFFFFF00, 64'hFFFFFFFF_FFFFFF00, 1'b0, 1'b0, 32'd0, 32'd0);

    // Second pair offered at E5 must be dropped
    do_op("interfere", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, 1'b1, 1'b0, 32'd0, 32'd0);

    // Back-to-back: next pair offered while the result pulse is on the bus
    do_op("chain1", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    do_op("chain2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001, 1'b0, 1'b0, 32'd0, 32'd0);

    // Only the dividend channel valid
    dvd = 32'd40; dvs = 32'd4; dvd_valid = 1'b1; dvs_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk); #1;
      seen = seen | s_busy | u_busy | s_tvalid | u_tvalid;
    end
    check("one-valid no accept", {63'd0, seen}, 64'd0);
    dvd_valid = 1'b0;
    @(posedge aclk); #1;

    // Reset at E10 of an operation
    dvd = 32'd1000; dvs = 32'd3; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge aclk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    check("rst op accept", {62'd0, s_busy, u_busy}, 64'd3);
    repeat (10) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check("rst async flags", {60'd0, s_tvalid, u_tvalid, s_busy, u_busy}, 64'd0);
    check("rst async tdata", s_tdata | u_tdata, 64'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge aclk); #1;
      seen = seen | s_tvalid | u_tvalid | s_busy | u_busy;
    end
    check("rst no pulse", {63'd0, seen}, 64'd0);

    do_op("9/3 after rst", 32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
